// File: rtl/if_fetch_stall.sv
// Instruction fetch stage with a one-entry output buffer, stall and redirect
// handling. Optional performance counters are built when IF_FETCH_PERF_EN is
// defined; otherwise the counter ports are tied to zero.
module if_fetch_stall #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_IF,
  input  logic        rst_IF,
  input  logic        en_IF,
  input  logic        branch_IF,
  input  logic [31:0] branch_target_IF,
  output logic        imem_req_IF,
  output logic [31:0] imem_addr_IF,
  input  logic        imem_ready_IF,
  input  logic [31:0] imem_rdata_IF,
  output logic [31:0] PC_out_IF,
  output logic [31:0] inst_out_IF,
  output logic        NOP_out_IF,
  output logic [31:0] perf_stall_cnt_IF,
  output logic [31:0] perf_redirect_cnt_IF
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q;
  logic            req_q;
  logic [XLEN-1:0] buf_pc_q, buf_inst_q;
  logic            buf_valid_q;
  logic [XLEN-1:0] target_al;
  logic            fill;

  assign target_al = {branch_target_IF[XLEN-1:2], 2'b00};

  // A returned word is only kept when the buffer has room (empty or drained
  // this edge); otherwise it is dropped and the same PC is re-requested later.
  assign fill = (state_q == FETCH) && imem_ready_IF && !branch_IF &&
                (!buf_valid_q || en_IF);

  // Next-state and next-PC decode; redirect has priority over everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (branch_IF) begin
      pc_d = target_al;
    end else if (fill) begin
      pc_d = pc_q + PC_STEP;
    end
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (branch_IF) begin
          state_d = imem_ready_IF ? FETCH : DRAIN;
        end else if (imem_ready_IF && !fill) begin
          state_d = FULL;
        end
      end
      FULL:  begin
        if (branch_IF || en_IF) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ready_IF) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, PC, request and buffer registers.
  always_ff @(posedge clk_IF or posedge rst_IF) begin
    if (rst_IF) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      req_addr_q  <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= (state_d == FETCH) || (state_d == DRAIN);
      // A draining request keeps its original address until it completes.
      if (state_d != DRAIN) begin
        req_addr_q <= pc_d;
      end
      if (branch_IF) begin
        buf_valid_q <= 1'b0;
      end else if (fill) begin
        buf_valid_q <= 1'b1;
        buf_pc_q    <= pc_q;
        buf_inst_q  <= imem_rdata_IF;
      end else if (en_IF) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

  assign imem_req_IF  = req_q;
  assign imem_addr_IF = req_addr_q;
  assign PC_out_IF    = buf_pc_q;
  assign inst_out_IF  = buf_inst_q;
  assign NOP_out_IF   = !buf_valid_q || branch_IF;

`ifdef IF_FETCH_PERF_EN
  logic [XLEN-1:0] stall_cnt_q, redirect_cnt_q;

  // Bubble cycles while fetching and redirect cycles, both wrapping.
  always_ff @(posedge clk_IF or posedge rst_IF) begin
    if (rst_IF) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if ((state_q != IDLE) && !buf_valid_q) begin
        stall_cnt_q <= stall_cnt_q + XLEN'(1);
      end
      if (branch_IF) begin
        redirect_cnt_q <= redirect_cnt_q + XLEN'(1);
      end
    end
  end

  assign perf_stall_cnt_IF    = stall_cnt_q;
  assign perf_redirect_cnt_IF = redirect_cnt_q;
`else
  assign perf_stall_cnt_IF    = '0;
  assign perf_redirect_cnt_IF = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stall.sv
// Self-checking bench for if_fetch_stall: directed scenarios plus random
// stimulus compared against a transaction-level model of the fetch stage.
module tb_if_fetch_stall;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_IF = 1'b0;
  logic        rst_IF;
  logic        en_IF;
  logic        branch_IF;
  logic [31:0] branch_target_IF;
  logic        imem_req_IF;
  logic [31:0] imem_addr_IF;
  logic        imem_ready_IF;
  logic [31:0] imem_rdata_IF;
  logic [31:0] PC_out_IF;
  logic [31:0] inst_out_IF;
  logic        NOP_out_IF;
  logic [31:0] perf_stall_cnt_IF;
  logic [31:0] perf_redirect_cnt_IF;

  int checks   = 0;
  int failures = 0;

  // Model state: outstanding request, discard flag, one-entry buffer.
  logic        m_started, m_req, m_squash, m_bv;
  logic [31:0] m_pc, m_addr, m_bpc, m_binst;
  logic [31:0] m_stall, m_redir;

  if_fetch_stall #(.RESET_PC(RST_PC)) dut (
    .clk_IF               (clk_IF),
    .rst_IF               (rst_IF),
    .en_IF                (en_IF),
    .branch_IF            (branch_IF),
    .branch_target_IF     (branch_target_IF),
    .imem_req_IF          (imem_req_IF),
    .imem_addr_IF         (imem_addr_IF),
    .imem_ready_IF        (imem_ready_IF),
    .imem_rdata_IF        (imem_rdata_IF),
    .PC_out_IF            (PC_out_IF),
    .inst_out_IF          (inst_out_IF),
    .NOP_out_IF           (NOP_out_IF),
    .perf_stall_cnt_IF    (perf_stall_cnt_IF),
    .perf_redirect_cnt_IF (perf_redirect_cnt_IF)
  );

  always #5 clk_IF = ~clk_IF;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  // Instruction memory: data is a fixed function of the address.
  assign imem_rdata_IF = mem_word(imem_addr_IF);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_req     = 1'b0;
    m_squash  = 1'b0;
    m_bv      = 1'b0;
    m_pc      = RST_PC;
    m_addr    = RST_PC;
    m_bpc     = 32'h0;
    m_binst   = 32'h0000_0013;
    m_stall   = 32'h0;
    m_redir   = 32'h0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [31:0] tgt, npc;
    logic        took, refused;
    tgt = {branch_target_IF[31:2], 2'b00};
    if (m_started && !m_bv) m_stall = m_stall + 32'd1;
    if (branch_IF)          m_redir = m_redir + 32'd1;
    if (!m_started) begin
      m_started = 1'b1;
      if (branch_IF) m_pc = tgt;
      m_req    = 1'b1;
      m_addr   = m_pc;
      m_squash = 1'b0;
      return;
    end
    took    = m_req && imem_ready_IF && !m_squash && !branch_IF && (!m_bv || en_IF);
    refused = m_req && imem_ready_IF && !m_squash && !branch_IF && m_bv && !en_IF;
    npc = branch_IF ? tgt : (took ? m_addr + 32'd4 : m_pc);
    if (branch_IF) begin
      m_bv = 1'b0;
    end else if (took) begin
      m_bv    = 1'b1;
      m_bpc   = m_addr;
      m_binst = mem_word(m_addr);
    end else if (en_IF) begin
      m_bv = 1'b0;
    end
    if (m_req && !imem_ready_IF) begin
      if (branch_IF) m_squash = 1'b1;
    end else if (refused) begin
      m_req = 1'b0;
    end else if (m_req || branch_IF || en_IF) begin
      m_req    = 1'b1;
      m_addr   = npc;
      m_squash = 1'b0;
    end
    m_pc = npc;
  endtask

  task automatic check_all();
    logic [31:0] exp_stall, exp_redir;
`ifdef IF_FETCH_PERF_EN
    exp_stall = m_stall;
    exp_redir = m_redir;
`else
    exp_stall = 32'h0;
    exp_redir = 32'h0;
`endif
    chk("req", 32'(imem_req_IF), 32'(m_req));
    if (m_req) chk("addr", imem_addr_IF, m_addr);
    chk("nop", 32'(NOP_out_IF), 32'(!m_bv || branch_IF));
    chk("pc_out", PC_out_IF, m_bpc);
    chk("inst_out", inst_out_IF, m_binst);
    chk("stall_cnt", perf_stall_cnt_IF, exp_stall);
    chk("redir_cnt", perf_redirect_cnt_IF, exp_redir);
  endtask

  // One clock cycle: apply inputs, check mid-cycle, step the model at the edge.
  task automatic tick(input logic en, input logic br, input logic [31:0] tgt, input logic rdy);
    en_IF            = en;
    branch_IF        = br;
    branch_target_IF = tgt;
    imem_ready_IF    = rdy;
    @(negedge clk_IF);
    check_all();
    @(posedge clk_IF);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_IF           = 1'b1;
    en_IF            = 1'b0;
    branch_IF        = 1'b0;
    branch_target_IF = 32'h0;
    imem_ready_IF    = 1'b0;
    model_reset();
    @(negedge clk_IF);
    check_all();
    @(posedge clk_IF);
    #1;
    rst_IF = 1'b0;
  endtask

  initial begin
    do_reset();

    // Streaming with zero-wait memory.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stream_addr", imem_addr_IF, 32'd20);
    chk("stream_pc_out", PC_out_IF, 32'd16);

    // Stall with buffer holding PC 8, then release.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_buf_pc", PC_out_IF, 32'd8);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stall_req", 32'(imem_req_IF), 32'd0);
    chk("stall_hold_pc", PC_out_IF, 32'd8);
    chk("stall_hold_inst", inst_out_IF, mem_word(32'd8));
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_next_addr", imem_addr_IF, 32'd12);
    chk("stall_next_req", 32'(imem_req_IF), 32'd1);

    // Redirect while a request at 16 is outstanding.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h0, 1'b1);
    chk("drain_pre_addr", imem_addr_IF, 32'd16);
    tick(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("drain_hold_addr", imem_addr_IF, 32'd16);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    chk("drain_new_addr", imem_addr_IF, 32'h0000_0100);
    chk("drain_dropped", 32'(NOP_out_IF), 32'd1);

    // PC wraps from the top of the address space.
    do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("wrap_addr_top", imem_addr_IF, 32'hFFFF_FFFC);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr_zero", imem_addr_IF, 32'h0000_0000);
    chk("wrap_pc_out", PC_out_IF, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a stalled request.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    imem_ready_IF = 1'b0;
    en_IF = 1'b0;
    #2;
    rst_IF = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req_IF), 32'd0);
    chk("arst_nop", 32'(NOP_out_IF), 32'd1);
    chk("arst_pc_out", PC_out_IF, 32'h0);
    chk("arst_inst", inst_out_IF, 32'h0000_0013);
    do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("arst_first_addr", imem_addr_IF, RST_PC);
    chk("arst_first_req", 32'(imem_req_IF), 32'd1);

    // Counters: five bubble cycles and two redirects.
    do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    tick(1'b1, 1'b1, 32'h0000_0080, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
`ifdef IF_FETCH_PERF_EN
    chk("perf_stall", perf_stall_cnt_IF, 32'd5);
    chk("perf_redir", perf_redirect_cnt_IF, 32'd2);
`else
    chk("perf_stall_off", perf_stall_cnt_IF, 32'd0);
    chk("perf_redir_off", perf_redirect_cnt_IF, 32'd0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0,
           $urandom,
           $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
